// File: rtl/serial_sub_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor.
// The master side (a sequencer) issues start with operands and watches busy/done.
// The slave side (serial_sub) returns the difference and the borrow-out.
interface serial_sub_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             b_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] d;
  logic             b_out;

  modport master (
    output start, a, b, b_in,
    input  busy, done, d, b_out
  );

  modport slave (
    input  start, a, b, b_in,
    output busy, done, d, b_out
  );
endinterface

// File: rtl/serial_sub.sv
// Bit-serial unsigned subtractor: d = a - b - b_in, processed LSB-first.
// A single full-subtractor cell and a borrow flip-flop are reused over WIDTH
// clock cycles. The result and borrow-out are registered and held until the
// next completion.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for start; outputs hold the last result
// S_SHIFT | one bit-step per cycle, busy=1
// S_DONE  | single-cycle done pulse; start here is accepted back-to-back
module serial_sub #(
  parameter int WIDTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  serial_sub_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;

  logic [WIDTH-1:0] a_sr_q;
  logic [WIDTH-1:0] b_sr_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] res_d;
  logic [WIDTH-1:0] d_q;
  logic [CNT_W-1:0] cnt_q;
  logic             br_q;
  logic             b_out_q;

  logic             accept;
  logic             step;
  logic             last_step;
  logic             busy;
  logic             done;

  logic             ai;
  logic             bi;
  logic             diff;
  logic             br_next;

  // Full-subtractor cell operating on the current LSBs and the borrow FF.
  assign ai        = a_sr_q[0];
  assign bi        = b_sr_q[0];
  assign diff      = ai ^ bi ^ br_q;
  assign br_next   = (~ai & bi) | (~(ai ^ bi) & br_q);

  // The difference bit enters from the MSB side so that after WIDTH steps the
  // LSB computed first has reached bit 0.
  assign res_d     = {diff, res_q[WIDTH-1:1]};
  assign last_step = (cnt_q == CNT_W'(WIDTH - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode and handshake outputs.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    step    = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          accept  = 1'b1;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        busy = 1'b1;
        step = 1'b1;
        if (last_step) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done = 1'b1;
        if (bus.start) begin
          accept  = 1'b1;
          state_d = S_SHIFT;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Operand shift registers, borrow FF and bit counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr_q <= '0;
      b_sr_q <= '0;
      res_q  <= '0;
      br_q   <= 1'b0;
      cnt_q  <= '0;
    end else if (accept) begin
      a_sr_q <= bus.a;
      b_sr_q <= bus.b;
      res_q  <= '0;
      br_q   <= bus.b_in;
      cnt_q  <= '0;
    end else if (step) begin
      a_sr_q <= {1'b0, a_sr_q[WIDTH-1:1]};
      b_sr_q <= {1'b0, b_sr_q[WIDTH-1:1]};
      res_q  <= res_d;
      br_q   <= br_next;
      cnt_q  <= cnt_q + 1'b1;
    end
  end

  // Result registers only move on the completing bit-step.
  always_ff @(posedge clk) begin
    if (rst) begin
      d_q     <= '0;
      b_out_q <= 1'b0;
    end else if (step && last_step) begin
      d_q     <= res_d;
      b_out_q <= br_next;
    end
  end

  assign bus.busy  = busy;
  assign bus.done  = done;
  assign bus.d     = d_q;
  assign bus.b_out = b_out_q;

endmodule

// File: tb/tb_serial_sub.sv
// Randomised scoreboard bench for serial_sub (WIDTH=4 main instance plus a
// WIDTH=8 instance for the wide-operand case).
module tb_serial_sub;

  localparam int W  = 4;
  localparam int W8 = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_sub_if #(.WIDTH(W))  bus4 ();
  serial_sub_if #(.WIDTH(W8)) bus8 ();

  serial_sub #(.WIDTH(W))  dut  (.clk(clk), .rst(rst), .bus(bus4));
  serial_sub #(.WIDTH(W8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

  typedef struct {
    int             acc;
    logic [W-1:0]   d;
    logic           bo;
  } exp_t;

  exp_t         q[$];
  int           total = 0;
  int           bad = 0;
  int           cyc = 0;
  int           next_ok = 0;
  logic [W-1:0] hold_d = '0;
  logic         hold_bo = 1'b0;
  bit           mon_en = 1'b0;
  bit           m_exp_done;
  bit           m_exp_busy;
  exp_t         m_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: plain integer subtraction; low W bits of the two's complement
  // result are the value mod 2^W, borrow-out is the unsigned comparison.
  function automatic logic [W:0] ref_sub(input int a, input int b, input int bi);
    int         r;
    logic [W:0] res;
    r          = a - b - bi;
    res[W-1:0] = r[W-1:0];
    res[W]     = (a < b + bi);
    return res;
  endfunction

  // Monitor: compares handshake timing and results against the scoreboard.
  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      m_exp_done = (q.size() > 0) && (q[0].acc + W == cyc);
      m_exp_busy = (q.size() > 0) && (cyc >= q[0].acc) && (cyc < q[0].acc + W);
      chk("busy", 32'(bus4.busy), 32'(m_exp_busy));
      chk("done", 32'(bus4.done), 32'(m_exp_done));
      if (bus4.busy && bus4.done) chk("busy_and_done", 32'(bus4.done), 32'(0));
      if ((bus4.done || m_exp_done) && q.size() > 0) begin
        m_e     = q.pop_front();
        hold_d  = m_e.d;
        hold_bo = m_e.bo;
        chk("d", 32'(bus4.d), 32'(m_e.d));
        chk("b_out", 32'(bus4.b_out), 32'(m_e.bo));
      end else begin
        chk("d_held", 32'(bus4.d), 32'(hold_d));
        chk("b_out_held", 32'(bus4.b_out), 32'(hold_bo));
      end
    end
  end

  // Issue one operation on the WIDTH=4 instance. While the previous operation
  // is still running, either junk is driven (random start and operands) or, in
  // hold mode, start is kept high with the new operands already presented.
  task automatic issue(input int a, input int b, input int bi, input int gap, input bit hold_start);
    logic [W:0] r;
    int         g;
    g = gap;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (cyc + 1 >= next_ok && g == 0) begin
        bus4.start = 1'b1;
        bus4.a     = W'(a);
        bus4.b     = W'(b);
        bus4.b_in  = 1'(bi);
        r = ref_sub(a, b, bi);
        q.push_back('{acc: cyc + 1, d: r[W-1:0], bo: r[W]});
        next_ok = cyc + 1 + W + 1;
        return;
      end
      if (cyc + 1 >= next_ok) begin
        g--;
        bus4.start = 1'b0;
        bus4.a     = W'($urandom);
        bus4.b     = W'($urandom);
        bus4.b_in  = 1'($urandom);
      end else if (hold_start) begin
        bus4.start = 1'b1;
        bus4.a     = W'(a);
        bus4.b     = W'(b);
        bus4.b_in  = 1'(bi);
      end else begin
        bus4.start = 1'($urandom);
        bus4.a     = W'($urandom);
        bus4.b     = W'($urandom);
        bus4.b_in  = 1'($urandom);
      end
    end
    chk("issue_budget", 32'(k_unused()), 32'(1));
  endtask

  function automatic int k_unused();
    return 0;
  endfunction

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (cyc + 1 >= next_ok) bus4.start = 1'b0;
      else bus4.start = 1'($urandom);
      bus4.a    = W'($urandom);
      bus4.b    = W'($urandom);
      bus4.b_in = 1'($urandom);
    end
  endtask

  task automatic reset_now(input bit with_start);
    @(negedge clk);
    rst        = 1'b1;
    bus4.start = with_start;
    q.delete();
    hold_d  = '0;
    hold_bo = 1'b0;
    next_ok = cyc + 2;
    @(negedge clk);
    rst        = 1'b0;
    bus4.start = 1'b0;
  endtask

  // One operation on the WIDTH=8 instance, checked inline with a cycle bound.
  task automatic op8(input int a, input int b, input int bi);
    int  acc8;
    int  r;
    bit  seen;
    logic [W8-1:0] ed;
    @(negedge clk);
    bus8.start = 1'b1;
    bus8.a     = W8'(a);
    bus8.b     = W8'(b);
    bus8.b_in  = 1'(bi);
    acc8 = cyc + 1;
    r    = a - b - bi;
    ed   = r[W8-1:0];
    @(negedge clk);
    bus8.start = 1'b0;
    bus8.a     = W8'($urandom);
    bus8.b     = W8'($urandom);
    chk("w8_busy", 32'(bus8.busy), 32'(1));
    seen = 1'b0;
    for (int k = 0; k < 30 && !seen; k++) begin
      if (bus8.done) seen = 1'b1;
      else @(negedge clk);
    end
    chk("w8_done_seen", 32'(bus8.done), 32'(1));
    if (seen) begin
      chk("w8_latency", 32'(cyc - acc8), 32'(W8));
      chk("w8_d", 32'(bus8.d), 32'(ed));
      chk("w8_b_out", 32'(bus8.b_out), 32'(a < b + bi));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus4.start = 1'b0; bus4.a = '0; bus4.b = '0; bus4.b_in = 1'b0;
    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.b_in = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(bus4.busy), 32'(0));
    chk("rst_done", 32'(bus4.done), 32'(0));
    chk("rst_d", 32'(bus4.d), 32'(0));
    chk("rst_b_out", 32'(bus4.b_out), 32'(0));
    chk("rst8_busy", 32'(bus8.busy), 32'(0));
    chk("rst8_d", 32'(bus8.d), 32'(0));
    rst     = 1'b0;
    next_ok = cyc + 1;
    mon_en  = 1'b1;

    // Wide operands: 0x00 - 0xFF - 1 wraps to 0x00 with borrow.
    op8(8'h00, 8'hFF, 1);
    op8(8'hA5, 8'h5A, 0);
    for (int i = 0; i < 6; i++) op8($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 1));
    idle(2);

    // Directed cases, then held-start back-to-back with operands changing mid-op.
    issue(9, 3, 0, 0, 1'b0);
    issue(3, 9, 0, 1, 1'b0);
    issue(0, 0, 1, 0, 1'b0);
    issue(15, 15, 1, 0, 1'b0);
    issue(15, 0, 0, 2, 1'b0);
    idle(W + 3);
    issue(9, 3, 0, 0, 1'b0);
    issue(1, 2, 0, 0, 1'b1);
    idle(W + 3);

    // Abort two edges into an operation; no done pulse may follow.
    issue(9, 3, 0, 0, 1'b0);
    idle(1);
    reset_now(1'b0);
    idle(W + 4);
    // Reset coinciding with a start request: the request is dropped.
    reset_now(1'b1);
    idle(3);

    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int bi = 0; bi < 2; bi++)
          issue(a, b, bi, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0, 1'($urandom));

    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 40) == 0) reset_now(1'($urandom));
      issue($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 1),
            $urandom_range(0, 2), 1'($urandom));
    end

    idle(W + 4);
    @(negedge clk);
    chk("queue_empty", 32'(q.size()), 32'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
